// File: rtl/alu_serial_pkg.sv
// Shared types for the digit-serial ALU: opcode and control-state encodings.
package alu_serial_pkg;

  typedef enum logic [1:0] {
    OP_NOR = 2'b00,
    OP_XOR = 2'b01,
    OP_ADD = 2'b10,
    OP_SUB = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  // ADD and SUB are the only opcodes that use the carry chain.
  function automatic logic is_arith(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/alu_digit.sv
// Combinational DIGIT-wide ALU slice; also exposes the carry into its MSB
// so the top level can derive signed overflow on the final digit.
module alu_digit
  import alu_serial_pkg::*;
#(
  parameter int DIGIT = 8
) (
  input  logic [DIGIT-1:0] a_d,
  input  logic [DIGIT-1:0] b_d,
  input  logic             cin_d,
  input  op_e              op,
  output logic [DIGIT-1:0] s_d,
  output logic             cout_d,
  output logic             c_msb
);

  logic [DIGIT-1:0] w_b_eff;
  logic [DIGIT:0]   w_sum;

  assign w_b_eff = (op == OP_SUB) ? ~b_d : b_d;
  assign w_sum   = {1'b0, a_d} + {1'b0, w_b_eff} + {{DIGIT{1'b0}}, cin_d};

  always_comb begin
    s_d    = w_sum[DIGIT-1:0];
    cout_d = w_sum[DIGIT];
    // sum bit = a ^ b ^ carry-in, so the carry into the MSB falls out directly
    c_msb  = w_sum[DIGIT-1] ^ a_d[DIGIT-1] ^ w_b_eff[DIGIT-1];
    case (op)
      OP_NOR: begin
        s_d    = ~(a_d | b_d);
        cout_d = 1'b0;
        c_msb  = 1'b0;
      end
      OP_XOR: begin
        s_d    = a_d ^ b_d;
        cout_d = 1'b0;
        c_msb  = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_serial.sv
// Multi-cycle ALU: processes WIDTH bits DIGIT at a time, LSB digit first,
// with a registered carry between digits and valid/ready on both sides.
module alu_serial
  import alu_serial_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DIGIT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  state_e           r_state, w_state_next;
  logic [WIDTH-1:0] r_a, r_b, r_s;
  op_e              r_op;
  logic             r_carry, r_cout, r_ovf, r_zero;
  logic [CW-1:0]    r_cnt;
  logic [DIGIT-1:0] w_s_d;
  logic             w_cout_d, w_c_msb, w_accept, w_last;
  logic [WIDTH-1:0] w_full;

  assign w_accept = in_valid && in_ready;
  assign w_last   = (r_state == RUN) && (r_cnt == LAST);

  alu_digit #(.DIGIT(DIGIT)) u_digit (
    .a_d    (r_a[DIGIT-1:0]),
    .b_d    (r_b[DIGIT-1:0]),
    .cin_d  (r_carry),
    .op     (r_op),
    .s_d    (w_s_d),
    .cout_d (w_cout_d),
    .c_msb  (w_c_msb)
  );

  // Partial result: new digit enters at the top, earlier digits slide down.
  generate
    if (NDIG == 1) begin : g_single
      assign w_full = w_s_d;
    end else begin : g_multi
      logic [WIDTH-DIGIT-1:0] r_acc;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                r_acc <= '0;
        else if (r_state == RUN)   r_acc <= w_full[WIDTH-1:DIGIT];
      end
      assign w_full = {w_s_d, r_acc};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (in_valid)        w_state_next = RUN;
      RUN:     if (r_cnt == LAST)   w_state_next = DONE;
      DONE:    if (out_ready)       w_state_next = IDLE;
      default:                      w_state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= OP_NOR;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_s     <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_op    <= op_e'(op);
      r_carry <= is_arith(op) & cin;
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      r_a     <= r_a >> DIGIT;
      r_b     <= r_b >> DIGIT;
      r_carry <= w_cout_d;
      r_cnt   <= r_cnt + 1'b1;
      // Visible outputs only change on the final digit, so they hold the
      // previous result throughout RUN.
      if (w_last) begin
        r_s    <= w_full;
        r_cout <= w_cout_d;
        r_ovf  <= w_c_msb ^ w_cout_d;
        r_zero <= (w_full == '0);
      end
    end
  end

  assign s    = r_s;
  assign cout = r_cout;
  assign ovf  = r_ovf;
  assign zero = r_zero;

endmodule

// File: tb/tb_alu_serial.sv
// Directed bench for alu_serial: reference model plus scoreboard checked on
// every result cycle, and literal expectations for the listed scenarios.
module tb_alu_serial;
  import alu_serial_pkg::*;

  localparam int W    = 64;
  localparam int D    = 8;
  localparam int NDIG = W / D;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic [1:0]   op = 2'b00;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] s;
  logic         cout, ovf, zero;

  alu_serial #(.WIDTH(W), .DIGIT(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;
    logic         zero;
  } res_t;

  int   n_pass  = 0;
  int   n_total = 0;
  int   cyc     = 0;
  res_t exp_q[$];
  int   acc_q[$];
  bit   first_seen = 1'b1;
  res_t m_e;

  // Full-width reference: plain wide arithmetic, overflow from operand/result signs.
  function automatic res_t model(input logic [W-1:0] fa, input logic [W-1:0] fb,
                                 input logic fc, input logic [1:0] fop);
    res_t         r;
    logic [W-1:0] bb;
    logic [W:0]   sum;
    r = '0;
    case (fop)
      2'b00: r.s = ~(fa | fb);
      2'b01: r.s = fa ^ fb;
      default: begin
        bb    = (fop == 2'b11) ? ~fb : fb;
        sum   = {1'b0, fa} + {1'b0, bb} + {{W{1'b0}}, fc};
        r.s   = sum[W-1:0];
        r.cout = sum[W];
        r.ovf = (fa[W-1] == bb[W-1]) && (r.s[W-1] != fa[W-1]);
      end
    endcase
    r.zero = (r.s == '0);
    return r;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  always @(posedge clk) cyc++;

  // Scoreboard: queue model results at accept, check whenever out_valid is high.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      acc_q.delete();
      first_seen = 1'b1;
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out_valid", 1, 0);
        end else begin
          m_e = exp_q[0];
          chk("model_s", s, m_e.s);
          chk("model_cout", cout, m_e.cout);
          chk("model_ovf", ovf, m_e.ovf);
          chk("model_zero", zero, m_e.zero);
          chk("in_ready_in_done", in_ready, 0);
          if (first_seen) chk("latency", cyc - acc_q[0], NDIG);
          first_seen = 1'b0;
          if (out_ready) begin
            void'(exp_q.pop_front());
            void'(acc_q.pop_front());
            first_seen = 1'b1;
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, cin, op));
        acc_q.push_back(cyc + 1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input logic tc, input logic [1:0] top, input logic [W-1:0] es,
                        input logic ec, input logic eo, input logic ez,
                        input int hold, input bit poke);
    int           n;
    logic [W-1:0] s_snap;
    a = ta; b = tb_; cin = tc; op = top; in_valid = 1'b1;
    out_ready = (hold == 0);
    n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    tick();
    in_valid = 1'b0;
    if (poke) begin
      a = ~ta; b = ta; op = ~top; in_valid = 1'b1;
      tick(); tick(); tick();
      in_valid = 1'b0;
    end
    n = 0;
    while (!out_valid && n < 50) begin tick(); n++; end
    if (!out_valid) begin
      chk({name, "_timeout"}, 0, 1);
      out_ready = 1'b1;
      return;
    end
    $display("op %s: s=%h cout=%0b ovf=%0b zero=%0b", name, s, cout, ovf, zero);
    chk({name, "_s"}, s, es);
    chk({name, "_cout"}, cout, ec);
    chk({name, "_ovf"}, ovf, eo);
    chk({name, "_zero"}, zero, ez);
    s_snap = s;
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({name, "_held_valid"}, out_valid, 1);
      chk({name, "_held_s"}, s, s_snap);
      chk({name, "_held_in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    res_t r_pin;
    int   acc[$];
    int   seen;

    #1;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_s", s, 0);
    chk("reset_flags", {cout, ovf, zero}, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Pin the model to hand-computed values.
    r_pin = model(64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b0, OP_ADD);
    chk("pin_add_ovf_s", r_pin.s, 64'h7FFF_FFFF_FFFF_FFFF);
    chk("pin_add_ovf_flags", {r_pin.cout, r_pin.ovf, r_pin.zero}, 3'b110);
    r_pin = model(64'd5, 64'd7, 1'b1, OP_SUB);
    chk("pin_sub_s", r_pin.s, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("pin_sub_flags", {r_pin.cout, r_pin.ovf, r_pin.zero}, 3'b000);

    run_op("add_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 1'b0, OP_ADD,
           64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    run_op("add_ovf", 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b0, OP_ADD,
           64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    run_op("sub_neg", 64'd5, 64'd7, 1'b1, OP_SUB,
           64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    run_op("sub_zero", 64'd7, 64'd7, 1'b1, OP_SUB, 64'd0, 1'b1, 1'b0, 1'b1, 0, 1'b0);
    run_op("nor_zero", 64'd0, 64'd0, 1'b1, OP_NOR,
           64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    run_op("xor_same", 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0, OP_XOR,
           64'd0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    run_op("hold_done", 64'h0000_0000_0000_00FF, 64'h0000_0000_0000_0001, 1'b0, OP_ADD,
           64'h0000_0000_0000_0100, 1'b0, 1'b0, 1'b0, 5, 1'b0);
    run_op("ignore_run", 64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0, OP_ADD,
           64'h1234_5678_9ABC_DF00, 1'b0, 1'b0, 1'b0, 0, 1'b1);

    // Back-to-back with out_ready high: accepts every NDIG+2 cycles.
    a = 64'd3; b = 64'd4; cin = 1'b0; op = OP_ADD; out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 35; i++) begin
      @(negedge clk);
      if (in_valid && in_ready) acc.push_back(cyc);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    $display("b2b: %0d accepts", acc.size());
    chk("b2b_accepts", acc.size(), 4);
    if (acc.size() >= 3) begin
      chk("b2b_gap1", acc[1] - acc[0], NDIG + 2);
      chk("b2b_gap2", acc[2] - acc[1], NDIG + 2);
    end
    for (int i = 0; i < 15; i++) tick();

    // Reset while RUN counter is 3.
    a = 64'hDEAD_BEEF_0000_0001; b = 64'd1; cin = 1'b0; op = OP_ADD; in_valid = 1'b1;
    seen = 0;
    while (!in_ready && seen < 50) begin tick(); seen++; end
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    $display("reset mid-run: in_ready=%0b out_valid=%0b", in_ready, out_valid);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_s", s, 0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) seen++;
    end
    chk("midrst_no_pulse", seen, 0);
    run_op("add_after_rst", 64'd1, 64'd1, 1'b0, OP_ADD, 64'd2, 1'b0, 1'b0, 1'b0, 0, 1'b0);

    tick(); tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
